// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline types for the memory stage: access sizes, the
// memory-stage FSM encoding, control bundle and the EX/MEM and MEM/WB
// pipeline registers, plus small helpers used by the alignment logic.
package riscv_pkg;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2
    } mem_size_t;

    typedef enum logic [1:0] {
        MEM_IDLE     = 2'd0,
        MEM_REQ      = 2'd1,
        MEM_WAIT_RSP = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic      reg_write;
        logic      mem_to_reg;
        logic      mem_read;
        logic      mem_write;
        mem_size_t mem_size;
        logic      mem_unsigned;
    } ctrl_t;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] rs2_data;
        logic [4:0]  rd;
        ctrl_t       ctrl;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] mem_data;
        logic [4:0]  rd;
        ctrl_t       ctrl;
    } mem_wb_t;

    // Sign- or zero-extend the low byte/half of an already lane-shifted word.
    function automatic logic [31:0] extend_load(input logic [31:0] shifted,
                                                input mem_size_t   size,
                                                input logic        is_unsigned);
        logic [31:0] result;
        case (size)
            MEM_B:   result = is_unsigned ? {24'd0, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
            MEM_H:   result = is_unsigned ? {16'd0, shifted[15:0]}
                                          : {{16{shifted[15]}}, shifted[15:0]};
            default: result = shifted;
        endcase
        return result;
    endfunction

    // Halfwords need an even address, words need a 4-byte aligned address.
    // The unused size encoding is treated like a word access.
    function automatic logic is_misaligned(input logic [1:0] off,
                                           input mem_size_t  size);
        logic result;
        case (size)
            MEM_B:   result = 1'b0;
            MEM_H:   result = off[0];
            default: result = (off != 2'b00);
        endcase
        return result;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the data-memory port: store data replication and
// byte enables, load lane extraction with sign/zero extension, and
// misalignment detection. Purely combinational.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [1:0]  off,
    input  mem_size_t   size,
    input  logic        mem_read,
    input  logic        mem_unsigned,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [31:0] shifted_s;

    // Store data is replicated across lanes so the memory only needs the enables.
    always_comb begin
        wdata = store_data;
        be    = 4'b1111;
        if (!mem_read) begin
            case (size)
                MEM_B: begin
                    wdata = {4{store_data[7:0]}};
                    be    = 4'b0001 << off;
                end
                MEM_H: begin
                    wdata = {2{store_data[15:0]}};
                    be    = 4'b0011 << off;
                end
                default: begin
                    wdata = store_data;
                    be    = 4'b1111;
                end
            endcase
        end else begin
            be = 4'b1111;
        end
    end

    // Loads read the full word; move the addressed lane down and extend it.
    always_comb begin
        shifted_s = rdata >> {off, 3'b000};
        load_data = extend_load(shifted_s, size, mem_unsigned);
    end

    // Misalignment only depends on the low address bits and the size.
    always_comb begin
        misaligned = is_misaligned(off, size);
    end

endmodule

// File: rtl/mem_stage.sv
// RV32 memory stage: turns the EX/MEM register into data-memory requests,
// waits for the response while stalling the front of the pipeline, and
// produces the MEM/WB register. Misaligned accesses and response timeouts
// retire as bubbles with a one-cycle fault pulse.
module mem_stage
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 32'd255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  ex_mem_t     ex_mem_in,
    output mem_wb_t     mem_wb_out,
    output logic        mem_stall,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic        dmem_req_we,
    output logic [31:0] dmem_req_addr,
    output logic [31:0] dmem_req_wdata,
    output logic [3:0]  dmem_req_be,
    input  logic        dmem_rsp_valid,
    input  logic [31:0] dmem_rsp_rdata,
    output logic        misaligned_fault,
    output logic        bus_error
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 32'd2);

    mem_state_t       state_r;
    mem_state_t       state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    mem_wb_t          mem_wb_r;
    mem_wb_t          mem_wb_nxt_s;
    logic             misaligned_fault_r;
    logic             bus_error_r;
    logic             misaligned_nxt_s;
    logic             bus_error_nxt_s;

    logic             is_mem_s;
    logic             misaligned_s;
    logic             aligned_op_s;
    logic             timeout_hit_s;
    logic             stall_s;
    logic             req_valid_s;
    logic [31:0]      wdata_s;
    logic [3:0]       be_s;
    logic [31:0]      load_data_s;

    lsu_align u_lsu_align (
        .off          (ex_mem_in.alu_result[1:0]),
        .size         (ex_mem_in.ctrl.mem_size),
        .mem_read     (ex_mem_in.ctrl.mem_read),
        .mem_unsigned (ex_mem_in.ctrl.mem_unsigned),
        .store_data   (ex_mem_in.rs2_data),
        .rdata        (dmem_rsp_rdata),
        .wdata        (wdata_s),
        .be           (be_s),
        .load_data    (load_data_s),
        .misaligned   (misaligned_s)
    );

    // Classify the instruction currently held in EX/MEM.
    always_comb begin
        is_mem_s     = ex_mem_in.ctrl.mem_read | ex_mem_in.ctrl.mem_write;
        aligned_op_s = is_mem_s & ~misaligned_s;
    end

    // Timeout fires on the last allowed WAIT_RSP cycle; a zero limit disables it.
    always_comb begin
        if (TIMEOUT_CYCLES == 32'd0) begin
            timeout_hit_s = 1'b0;
        end else begin
            timeout_hit_s = (32'(cnt_r) == (TIMEOUT_CYCLES - 32'd1));
        end
    end

    // FSM transitions plus the request-valid and stall decode.
    always_comb begin
        state_nxt_s = state_r;
        stall_s     = 1'b0;
        req_valid_s = 1'b0;
        case (state_r)
            MEM_IDLE: begin
                if (aligned_op_s) begin
                    req_valid_s = 1'b1;
                    stall_s     = 1'b1;
                    state_nxt_s = dmem_req_ready ? MEM_WAIT_RSP : MEM_REQ;
                end else begin
                    state_nxt_s = MEM_IDLE;
                end
            end
            MEM_REQ: begin
                req_valid_s = 1'b1;
                stall_s     = 1'b1;
                state_nxt_s = dmem_req_ready ? MEM_WAIT_RSP : MEM_REQ;
            end
            MEM_WAIT_RSP: begin
                if (dmem_rsp_valid || timeout_hit_s) begin
                    stall_s     = 1'b0;
                    state_nxt_s = MEM_IDLE;
                end else begin
                    stall_s     = 1'b1;
                    state_nxt_s = MEM_WAIT_RSP;
                end
            end
            default: begin
                state_nxt_s = MEM_IDLE;
            end
        endcase
    end

    // Next MEM/WB contents and fault pulses; the register holds while stalled.
    always_comb begin
        mem_wb_nxt_s     = mem_wb_r;
        misaligned_nxt_s = 1'b0;
        bus_error_nxt_s  = 1'b0;
        case (state_r)
            MEM_IDLE: begin
                if (!is_mem_s) begin
                    mem_wb_nxt_s.alu_result = ex_mem_in.alu_result;
                    mem_wb_nxt_s.mem_data   = 32'd0;
                    mem_wb_nxt_s.rd         = ex_mem_in.rd;
                    mem_wb_nxt_s.ctrl       = ex_mem_in.ctrl;
                end else if (misaligned_s) begin
                    mem_wb_nxt_s     = '0;
                    misaligned_nxt_s = 1'b1;
                end else begin
                    mem_wb_nxt_s = mem_wb_r;
                end
            end
            MEM_WAIT_RSP: begin
                if (dmem_rsp_valid) begin
                    mem_wb_nxt_s.alu_result = ex_mem_in.alu_result;
                    mem_wb_nxt_s.mem_data   = ex_mem_in.ctrl.mem_read ? load_data_s : 32'd0;
                    mem_wb_nxt_s.rd         = ex_mem_in.rd;
                    mem_wb_nxt_s.ctrl       = ex_mem_in.ctrl;
                end else if (timeout_hit_s) begin
                    mem_wb_nxt_s    = '0;
                    bus_error_nxt_s = 1'b1;
                end else begin
                    mem_wb_nxt_s = mem_wb_r;
                end
            end
            default: begin
                mem_wb_nxt_s = mem_wb_r;
            end
        endcase
    end

    // State, wait counter, MEM/WB register and fault pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r            <= MEM_IDLE;
            cnt_r              <= '0;
            mem_wb_r           <= '0;
            misaligned_fault_r <= 1'b0;
            bus_error_r        <= 1'b0;
        end else begin
            state_r            <= state_nxt_s;
            mem_wb_r           <= mem_wb_nxt_s;
            misaligned_fault_r <= misaligned_nxt_s;
            bus_error_r        <= bus_error_nxt_s;
            if ((state_r == MEM_WAIT_RSP) && (state_nxt_s == MEM_WAIT_RSP)) begin
                cnt_r <= cnt_r + CNT_W'(1'b1);
            end else begin
                cnt_r <= '0;
            end
        end
    end

    // Request fields come straight from EX/MEM, which is frozen while stalled,
    // so they stay stable from first valid until acceptance.
    assign dmem_req_valid   = rst_n & req_valid_s;
    assign mem_stall        = rst_n & stall_s;
    assign dmem_req_we      = ex_mem_in.ctrl.mem_write;
    assign dmem_req_addr    = {ex_mem_in.alu_result[31:2], 2'b00};
    assign dmem_req_wdata   = wdata_s;
    assign dmem_req_be      = be_s;
    assign mem_wb_out       = mem_wb_r;
    assign misaligned_fault = misaligned_fault_r;
    assign bus_error        = bus_error_r;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: the stimulus pushes hand-computed
// expectations, a responder models the data memory, and a single monitor
// compares the DUT against the queue whenever an instruction retires.
module tb_mem_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    ex_mem_t     ex_mem_in;
    mem_wb_t     mem_wb_out;
    logic        mem_stall;
    logic        dmem_req_valid;
    logic        dmem_req_ready = 1'b0;
    logic        dmem_req_we;
    logic [31:0] dmem_req_addr;
    logic [31:0] dmem_req_wdata;
    logic [3:0]  dmem_req_be;
    logic        dmem_rsp_valid = 1'b0;
    logic [31:0] dmem_rsp_rdata = 32'd0;
    logic        misaligned_fault;
    logic        bus_error;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT_CYCLES(32'd4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ex_mem_in        (ex_mem_in),
        .mem_wb_out       (mem_wb_out),
        .mem_stall        (mem_stall),
        .dmem_req_valid   (dmem_req_valid),
        .dmem_req_ready   (dmem_req_ready),
        .dmem_req_we      (dmem_req_we),
        .dmem_req_addr    (dmem_req_addr),
        .dmem_req_wdata   (dmem_req_wdata),
        .dmem_req_be      (dmem_req_be),
        .dmem_rsp_valid   (dmem_rsp_valid),
        .dmem_rsp_rdata   (dmem_rsp_rdata),
        .misaligned_fault (misaligned_fault),
        .bus_error        (bus_error)
    );

    typedef struct {
        mem_wb_t     wb;
        bit          bubble;
        bit          mis;
        bit          berr;
        int          stall;
        int          reqs;
        logic        we;
        bit          chk_wdata;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic        tb_live = 1'b0;
    logic        tb_raw = 1'b0;
    logic        adv = 1'b0;
    logic        hang_seen = 1'b0;
    logic        done = 1'b0;
    int          ready_delay = 0;
    logic        rsp_en = 1'b0;
    logic        late_rsp = 1'b0;
    logic [31:0] rsp_data = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ex_mem_t mk_ins(input logic [31:0] alu, input logic [31:0] rs2,
                                       input logic [4:0] rd, input logic rw, input logic mr,
                                       input logic mw, input mem_size_t sz, input logic uns);
        ex_mem_t i;
        i.alu_result        = alu;
        i.rs2_data          = rs2;
        i.rd                = rd;
        i.ctrl.reg_write    = rw;
        i.ctrl.mem_to_reg   = mr;
        i.ctrl.mem_read     = mr;
        i.ctrl.mem_write    = mw;
        i.ctrl.mem_size     = sz;
        i.ctrl.mem_unsigned = uns;
        return i;
    endfunction

    function automatic exp_t mk_exp(input ex_mem_t ins, input logic [31:0] md, input int stall,
                                    input int reqs, input logic [31:0] addr, input logic [3:0] be);
        exp_t e;
        e.wb.alu_result = ins.alu_result;
        e.wb.mem_data   = md;
        e.wb.rd         = ins.rd;
        e.wb.ctrl       = ins.ctrl;
        e.bubble        = 1'b0;
        e.mis           = 1'b0;
        e.berr          = 1'b0;
        e.stall         = stall;
        e.reqs          = reqs;
        e.we            = ins.ctrl.mem_write;
        e.chk_wdata     = 1'b0;
        e.addr          = addr;
        e.wdata         = 32'd0;
        e.be            = be;
        return e;
    endfunction

    task automatic run_instr(input ex_mem_t ins, input exp_t e, input int delay,
                             input logic rsp_on, input logic [31:0] rdata, input logic late);
        bit ok;
        @(negedge clk);
        ready_delay = delay;
        rsp_en      = rsp_on;
        rsp_data    = rdata;
        late_rsp    = late;
        ex_mem_in   = ins;
        sb_q.push_back(e);
        tb_live     = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            late_rsp = 1'b0;
            if (adv) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) hang_seen = 1'b1;
        tb_live   = 1'b0;
        ex_mem_in = '0;
    endtask

    // Data-memory model: ready after a programmable delay, response one cycle after acceptance.
    initial begin
        int  wait_cnt;
        bit  acc_prev;
        wait_cnt = 0;
        acc_prev = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            dmem_rsp_valid = (acc_prev && rsp_en) || late_rsp;
            dmem_rsp_rdata = rsp_data;
            if (dmem_req_valid) begin
                if (wait_cnt >= ready_delay) begin
                    dmem_req_ready = 1'b1;
                end else begin
                    dmem_req_ready = 1'b0;
                    wait_cnt++;
                end
            end else begin
                dmem_req_ready = 1'b0;
                wait_cnt = 0;
            end
            acc_prev = dmem_req_valid && dmem_req_ready;
            if (acc_prev) wait_cnt = 0;
        end
    end

    // Monitor: the only process that compares; pops one entry per retired instruction.
    initial begin
        exp_t e;
        exp_t f;
        int   n_stall;
        int   n_req;
        n_stall = 0;
        n_req   = 0;
        forever begin
            @(negedge clk);
            #3;
            if (done) begin
                chk("sb_empty", 32'(sb_q.size()), 32'd0);
                chk("no_hang", 32'(hang_seen), 32'd0);
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
            if (!rst_n) begin
                chk("rst_wb_alu", mem_wb_out.alu_result, 32'd0);
                chk("rst_wb_data", mem_wb_out.mem_data, 32'd0);
                chk("rst_wb_rd", 32'(mem_wb_out.rd), 32'd0);
                chk("rst_wb_ctrl", 32'(mem_wb_out.ctrl), 32'd0);
                chk("rst_req_valid", 32'(dmem_req_valid), 32'd0);
                chk("rst_stall", 32'(mem_stall), 32'd0);
                chk("rst_mis", 32'(misaligned_fault), 32'd0);
                chk("rst_berr", 32'(bus_error), 32'd0);
                adv     = 1'b0;
                n_stall = 0;
                n_req   = 0;
            end else begin
                if (adv) begin
                    if (sb_q.size() == 0) begin
                        chk("sb_underflow", 32'd1, 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        if (e.bubble) begin
                            chk("wb_bubble_ctrl", 32'(mem_wb_out.ctrl), 32'd0);
                        end else begin
                            chk("wb_alu", mem_wb_out.alu_result, e.wb.alu_result);
                            chk("wb_mem_data", mem_wb_out.mem_data, e.wb.mem_data);
                            chk("wb_rd", 32'(mem_wb_out.rd), 32'(e.wb.rd));
                            chk("wb_ctrl", 32'(mem_wb_out.ctrl), 32'(e.wb.ctrl));
                        end
                        chk("misaligned_fault", 32'(misaligned_fault), 32'(e.mis));
                        chk("bus_error", 32'(bus_error), 32'(e.berr));
                        chk("stall_cycles", 32'(n_stall), 32'(e.stall));
                        chk("req_cycles", 32'(n_req), 32'(e.reqs));
                    end
                    adv     = 1'b0;
                    n_stall = 0;
                    n_req   = 0;
                end else begin
                    chk("no_mis_pulse", 32'(misaligned_fault), 32'd0);
                    chk("no_berr_pulse", 32'(bus_error), 32'd0);
                end
                if (tb_live) begin
                    if (dmem_req_valid) begin
                        n_req++;
                        if (sb_q.size() > 0) begin
                            f = sb_q[0];
                            chk("req_addr", dmem_req_addr, f.addr);
                            chk("req_we", 32'(dmem_req_we), 32'(f.we));
                            chk("req_be", 32'(dmem_req_be), 32'(f.be));
                            if (f.chk_wdata) chk("req_wdata", dmem_req_wdata, f.wdata);
                        end
                    end
                    if (mem_stall) n_stall++;
                    else adv = 1'b1;
                end else if (!tb_raw) begin
                    chk("idle_req_valid", 32'(dmem_req_valid), 32'd0);
                end
            end
        end
    end

    // Directed stimulus with hand-computed expectations.
    initial begin
        ex_mem_t ins;
        exp_t    e;
        rst_n     = 1'b0;
        ex_mem_in = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // ALU op passes straight through.
        ins = mk_ins(32'h0000_1234, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0, MEM_W, 1'b0);
        run_instr(ins, mk_exp(ins, 32'd0, 0, 0, 32'd0, 4'h0), 0, 1'b1, 32'd0, 1'b0);

        // LB / LBU at offset 3.
        ins = mk_ins(32'h0000_0103, 32'd0, 5'd7, 1'b1, 1'b1, 1'b0, MEM_B, 1'b0);
        run_instr(ins, mk_exp(ins, 32'hFFFF_FF80, 1, 1, 32'h0000_0100, 4'hF), 0, 1'b1, 32'h80FF_FF00, 1'b0);
        ins = mk_ins(32'h0000_0103, 32'd0, 5'd8, 1'b1, 1'b1, 1'b0, MEM_B, 1'b1);
        run_instr(ins, mk_exp(ins, 32'h0000_0080, 1, 1, 32'h0000_0100, 4'hF), 0, 1'b1, 32'h80FF_FF00, 1'b0);

        // LH / LHU at offset 2.
        ins = mk_ins(32'h0000_0102, 32'd0, 5'd9, 1'b1, 1'b1, 1'b0, MEM_H, 1'b0);
        run_instr(ins, mk_exp(ins, 32'hFFFF_8001, 1, 1, 32'h0000_0100, 4'hF), 0, 1'b1, 32'h8001_7FFF, 1'b0);
        ins = mk_ins(32'h0000_0102, 32'd0, 5'd10, 1'b1, 1'b1, 1'b0, MEM_H, 1'b1);
        run_instr(ins, mk_exp(ins, 32'h0000_8001, 1, 1, 32'h0000_0100, 4'hF), 0, 1'b1, 32'h8001_7FFF, 1'b0);

        // LW aligned.
        ins = mk_ins(32'h0000_0104, 32'd0, 5'd11, 1'b1, 1'b1, 1'b0, MEM_W, 1'b0);
        run_instr(ins, mk_exp(ins, 32'hDEAD_BEEF, 1, 1, 32'h0000_0104, 4'hF), 0, 1'b1, 32'hDEAD_BEEF, 1'b0);

        // SH at offset 2 with ready held low for 3 cycles.
        ins = mk_ins(32'h0000_0202, 32'hAAAA_BEEF, 5'd0, 1'b0, 1'b0, 1'b1, MEM_H, 1'b0);
        e = mk_exp(ins, 32'd0, 4, 4, 32'h0000_0200, 4'b1100);
        e.chk_wdata = 1'b1;
        e.wdata     = 32'hBEEF_BEEF;
        run_instr(ins, e, 3, 1'b1, 32'd0, 1'b0);

        // SB at offset 1.
        ins = mk_ins(32'h0000_0401, 32'h1234_5678, 5'd0, 1'b0, 1'b0, 1'b1, MEM_B, 1'b0);
        e = mk_exp(ins, 32'd0, 1, 1, 32'h0000_0400, 4'b0010);
        e.chk_wdata = 1'b1;
        e.wdata     = 32'h7878_7878;
        run_instr(ins, e, 0, 1'b1, 32'd0, 1'b0);

        // SW with one cycle of back-pressure.
        ins = mk_ins(32'h0000_010C, 32'hCAFE_F00D, 5'd0, 1'b0, 1'b0, 1'b1, MEM_W, 1'b0);
        e = mk_exp(ins, 32'd0, 2, 2, 32'h0000_010C, 4'hF);
        e.chk_wdata = 1'b1;
        e.wdata     = 32'hCAFE_F00D;
        run_instr(ins, e, 1, 1'b1, 32'd0, 1'b0);

        // Misaligned LW and SH retire as bubbles with a fault pulse.
        ins = mk_ins(32'h0000_0001, 32'd0, 5'd12, 1'b1, 1'b1, 1'b0, MEM_W, 1'b0);
        e = mk_exp(ins, 32'd0, 0, 0, 32'd0, 4'h0);
        e.bubble = 1'b1;
        e.mis    = 1'b1;
        run_instr(ins, e, 0, 1'b1, 32'd0, 1'b0);
        ins = mk_ins(32'h0000_0003, 32'h0000_5555, 5'd0, 1'b0, 1'b0, 1'b1, MEM_H, 1'b0);
        e = mk_exp(ins, 32'd0, 0, 0, 32'd0, 4'h0);
        e.bubble = 1'b1;
        e.mis    = 1'b1;
        run_instr(ins, e, 0, 1'b1, 32'd0, 1'b0);

        // No response: four WAIT_RSP cycles then bus_error and a bubble.
        ins = mk_ins(32'h0000_0300, 32'd0, 5'd13, 1'b1, 1'b1, 1'b0, MEM_W, 1'b0);
        e = mk_exp(ins, 32'd0, 4, 1, 32'h0000_0300, 4'hF);
        e.bubble = 1'b1;
        e.berr   = 1'b1;
        run_instr(ins, e, 0, 1'b0, 32'd0, 1'b0);

        // A late response arriving in IDLE must not disturb a following ALU op.
        ins = mk_ins(32'h0000_0055, 32'd0, 5'd3, 1'b1, 1'b0, 1'b0, MEM_W, 1'b0);
        run_instr(ins, mk_exp(ins, 32'd0, 0, 0, 32'd0, 4'h0), 0, 1'b0, 32'hFFFF_FFFF, 1'b1);

        // Reset while waiting: issued right after the ALU op so MEM/WB is non-zero.
        ins = mk_ins(32'h0000_0500, 32'd0, 5'd14, 1'b1, 1'b1, 1'b0, MEM_W, 1'b0);
        rsp_en      = 1'b0;
        ready_delay = 0;
        ex_mem_in   = ins;
        tb_raw      = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        ex_mem_in = '0;
        tb_raw    = 1'b0;
        rst_n     = 1'b1;

        // LW after reset release completes normally.
        ins = mk_ins(32'h0000_0108, 32'd0, 5'd15, 1'b1, 1'b1, 1'b0, MEM_W, 1'b0);
        run_instr(ins, mk_exp(ins, 32'h0BAD_F00D, 1, 1, 32'h0000_0108, 4'hF), 0, 1'b1, 32'h0BAD_F00D, 1'b0);

        repeat (3) @(negedge clk);
        done = 1'b1;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Consumes the EX/MEM pipeline register and performs RV32 loads and stores over a valid/ready data-memory port.
- Produces the MEM/WB pipeline register.
- Stalls the front of the pipeline while an access is outstanding.
- Handles byte-lane steering, load sign/zero extension, misalignment detection and a response timeout.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles in WAIT_RSP before bus_error. 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- ex_mem_in  in  ex_mem_t  EX/MEM register: alu_result, rs2_data, rd, ctrl
- mem_wb_out  out  mem_wb_t  MEM/WB register: alu_result, mem_data, rd, ctrl
- mem_stall  out  1  comb; holds PC, IF/ID, ID/EX and EX/MEM
- dmem_req_valid  out  1  request valid
- dmem_req_ready  in  1  request accepted
- dmem_req_we  out  1  1 = store
- dmem_req_addr  out  32  word-aligned address {alu_result[31:2],2'b00}
- dmem_req_wdata  out  32  lane-replicated store data
- dmem_req_be  out  4  byte enables
- dmem_rsp_valid  in  1  response / write ack
- dmem_rsp_rdata  in  32  load data, full word
- misaligned_fault  out  1  registered one-cycle pulse
- bus_error  out  1  registered one-cycle pulse on timeout

Behaviour:
- Reset: clk, rst_n asynchronous, active-low. On reset:
  - state = IDLE, timeout counter = 0
  - mem_wb_out = '0
  - misaligned_fault = 0, bus_error = 0
  - dmem_req_valid = 0
- Reset mid-access: abandon the access. Late rsp_valid after reset is ignored.
- ctrl fields used: mem_read, mem_write, mem_size (0 = B, 1 = H, 2 = W), mem_unsigned.
- Upstream contract: ex_mem_in advances on every clock edge where mem_stall = 0 and holds stable otherwise.
- Non-memory instruction, or mem_read = mem_write = 0:
  - mem_wb_out <= {alu_result, 0, rd, ctrl} next edge.
  - mem_stall = 0.
- Misaligned access: H with addr[0] = 1, or W with addr[1:0] != 0.
  - No request is issued; mem_stall = 0.
  - mem_wb_out <= bubble (ctrl = '0) next edge.
  - misaligned_fault pulses 1 cycle.
- FSM states IDLE, REQ, WAIT_RSP. dmem_req_valid = (state == IDLE && aligned memory op) || state == REQ.
- IDLE:
  - valid & ready -> WAIT_RSP.
  - valid & !ready -> REQ.
- REQ: hold addr/we/wdata/be stable until ready. On ready -> WAIT_RSP.
- WAIT_RSP: count cycles.
  - On rsp_valid:
    - mem_stall = 0 that cycle.
    - mem_wb_out <= {alu_result, extracted load data (0 for stores), rd, ctrl}.
    - Return to IDLE.
  - Counter reaches TIMEOUT_CYCLES without rsp_valid:
    - mem_stall = 0.
    - mem_wb_out <= bubble.
    - bus_error pulse; return to IDLE.
- rsp_valid in IDLE or REQ: ignored.
- mem_stall = 1 in every cycle of an aligned memory op except the completion/timeout cycle.
  - Minimum: 1 stall cycle (req accepted in cycle 0, rsp in cycle 1).
- mem_wb_out is held unchanged on stalled edges. Repeated WB writes are idempotent, and MEM/WB forwarding stays valid.
- Store steering, off = addr[1:0]:
  - SB: wdata = {4{rs2[7:0]}}, be = 4'b0001 << off
  - SH: wdata = {2{rs2[15:0]}}, be = 4'b0011 << off
  - SW: wdata = rs2, be = 4'b1111
- Loads: dmem_req_be = 4'b1111. shifted = rdata >> (8 * off).
  - B: sign- or zero-extend shifted[7:0].
  - H: sign- or zero-extend shifted[15:0].
  - W: shifted.
  - Sign vs zero per mem_unsigned.

Decomposition:
- riscv_pkg:
  - mem_size_t enum (MEM_B, MEM_H, MEM_W)
  - mem_state_t enum
  - ctrl_t fields mem_read, mem_write, mem_size, mem_unsigned
  - ex_mem_t, mem_wb_t
- One sub-module, lsu_align (combinational): store wdata/be generation, load extraction/extension, misalignment detect. FSM and registers stay in mem_stage.

Test Plan:
- ALU op, alu_result = 0x1234, rd = 5, reg_write = 1 -> next edge mem_wb_out.alu_result = 0x1234, rd = 5; mem_stall never 1.
- LB addr 0x103, ready = 1, rsp next cycle rdata = 0x80FF_FF00 -> be = 4'hF, addr = 0x100, 1 stall cycle, mem_data = 0xFFFF_FF80. Same with LBU -> 0x0000_0080.
- SH addr 0x202, rs2 = 0xAAAA_BEEF, ready low 3 cycles -> req fields stable 4 cycles, wdata = 0xBEEF_BEEF, be = 4'b1100, we = 1; stall released on ack.
- LW addr 0x001 -> no dmem_req_valid, misaligned_fault 1 cycle, mem_wb_out.ctrl.reg_write = 0, mem_stall = 0.
- TIMEOUT_CYCLES = 4, request accepted, no rsp -> bus_error after 4 WAIT cycles, bubble written, state IDLE. Late rsp_valid ignored.
- rst_n low while in WAIT_RSP -> mem_wb_out = 0, req_valid = 0, stall = 0 immediately. Next LW after release completes normally.
